debounce_sync: RTL

Front-end conditioning stage that turns a raw, asynchronous, bouncy input (push-button, switch, external strobe) into the clean, clock-synchronous single-bit value consumed by the downstream D flip-flop / register stages. It synchronizes the raw level into `clk` and filters it through a stability counter. It publishes the debounced level plus optional one-cycle edge pulses.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_sync_chain.sv | 38 +++
 rtl/debounce_sync.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : debounce_pkg
// Brief   : Shared state encoding and default parameters for the debouncer.
// Revision: 1.0 - initial release
// ============================================================================
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1000000;

  function automatic logic is_wait(input state_e s);
    return (s == WAIT_HIGH) || (s == WAIT_LOW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_sync_chain.sv
`default_nettype none
// ============================================================================
// Module  : sync_chain
// Brief   : N-flop synchronizer, async + sync reset, reset value 0.
// Revision: 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_reset,
  input  logic sync_reset,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
    if (sync_reset) begin
      sync_d = '0;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
// Module  : debounce_sync
// Brief   : Synchronizer + stability-counter debouncer with optional edge
//           pulses (enabled by macro DEBOUNCE_EDGE_PULSE_EN).
// Revision: 1.0 - initial release
// ============================================================================
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH     = 20,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic async_reset,
  input  logic sync_reset,
  input  logic i_raw,
  output logic o_value,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 s_in;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 value_q, value_d;
  logic                 busy_q, busy_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .async_reset (async_reset),
    .sync_reset  (sync_reset),
    .i_d         (i_raw),
    .o_q         (s_in)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    if (sync_reset) begin
      state_d = IDLE_LOW;
      cnt_d   = '0;
      value_d = 1'b0;
    end else begin
      case (state_q)
        IDLE_LOW: begin
          if (s_in) begin
            state_d = WAIT_HIGH;
            cnt_d   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!s_in) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = IDLE_HIGH;
            value_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        IDLE_HIGH: begin
          if (!s_in) begin
            state_d = WAIT_LOW;
            cnt_d   = '0;
          end
        end
        WAIT_LOW: begin
          if (s_in) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = IDLE_LOW;
            value_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          value_d = 1'b0;
        end
      endcase
    end
  end

  // busy tracks the current state, so it lags state entry by one cycle
  always_comb begin
    busy_d = is_wait(state_q) & ~sync_reset;
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      value_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      busy_q  <= busy_d;
    end
  end

  assign o_value = value_q;
  assign o_busy  = busy_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // a clear forcing value low is not a real fall
  always_comb begin
    rise_d = ~sync_reset &  value_d & ~value_q;
    fall_d = ~sync_reset & ~value_d &  value_q;
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule
`default_nettype wire
